// File: rtl/bcd_pkg.sv
// Shared constants and FSM state encoding for the BCD divisibility checker.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned BCD_MAX     = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_digit_step.sv
// One Horner step: folds a single digit into the running remainder and binary value.
module bcd_digit_step
  import bcd_pkg::*;
#(
  parameter int unsigned DIVISOR = 3,
  parameter int unsigned BW      = 14
) (
  input  logic [$clog2(DIVISOR)-1:0] rem,
  input  logic [BW-1:0]              bin,
  input  logic [BCD_DIGIT_W-1:0]     d,
  output logic [$clog2(DIVISOR)-1:0] rem_next,
  output logic [BW-1:0]              bin_next,
  output logic                       d_err
);

  localparam int unsigned RW = $clog2(DIVISOR);
  // Wide enough for 10*(DIVISOR-1) + 15, the worst case with a malformed nibble.
  localparam int unsigned TW = $clog2(10 * (DIVISOR - 1) + 16);

  logic [TW-1:0] acc;

  // Remainder, binary accumulation and nibble range check for this digit.
  always_comb begin
    acc      = TW'(rem) * TW'(10) + TW'(d);
    rem_next = RW'(acc % TW'(DIVISOR));
    bin_next = bin * BW'(10) + BW'(d);
    d_err    = (d > BCD_DIGIT_W'(BCD_MAX));
  end

endmodule : bcd_digit_step

// File: rtl/bcd_divisibility_checker.sv
// Serial MSD-first BCD divisibility checker with valid/ready handshakes on both sides.
module bcd_divisibility_checker
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIVISOR    = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] in_bcd,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_divisible,
  output logic [$clog2(DIVISOR)-1:0]        out_remainder,
  output logic [$clog2(10**NUM_DIGITS)-1:0] out_binary,
  output logic                              out_bcd_err
);

  localparam int unsigned RW = $clog2(DIVISOR);
  localparam int unsigned BW = $clog2(10**NUM_DIGITS);
  localparam int unsigned DW = BCD_DIGIT_W * NUM_DIGITS;
  localparam int unsigned CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Reject parameter values outside the supported range at elaboration.
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("bcd_divisibility_checker: NUM_DIGITS must be in 1..8");
  end
  if (DIVISOR < 2 || DIVISOR > 16) begin : g_bad_divisor
    $error("bcd_divisibility_checker: DIVISOR must be in 2..16");
  end

  state_t state, state_d;

  logic [DW-1:0] sr;
  logic [RW-1:0] rem;
  logic [BW-1:0] bin;
  logic          err;
  logic [CW-1:0] cnt;

  logic          load;
  logic          step_en;
  logic          last;
  logic          in_ready_d;
  logic          out_valid_d;

  logic [BCD_DIGIT_W-1:0] digit;
  logic [RW-1:0]          rem_n;
  logic [BW-1:0]          bin_n;
  logic                   d_err;
  logic                   err_n;

  assign digit = sr[DW-1 -: BCD_DIGIT_W];
  assign err_n = err | d_err;

  bcd_digit_step #(
    .DIVISOR (DIVISOR),
    .BW      (BW)
  ) u_step (
    .rem      (rem),
    .bin      (bin),
    .d        (digit),
    .rem_next (rem_n),
    .bin_next (bin_n),
    .d_err    (d_err)
  );

  // State register plus registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d     = state;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    load        = 1'b0;
    step_en     = 1'b0;
    last        = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready) begin
          load       = 1'b1;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        step_en = 1'b1;
        if (cnt == CW'(NUM_DIGITS - 1)) begin
          last        = 1'b1;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        out_valid_d = 1'b1;
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // Digit shift register and running accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      rem <= '0;
      bin <= '0;
      err <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      sr  <= in_bcd;
      rem <= '0;
      bin <= '0;
      err <= 1'b0;
      cnt <= '0;
    end else if (step_en) begin
      sr  <= sr << BCD_DIGIT_W;
      rem <= rem_n;
      bin <= bin_n;
      err <= err_n;
      cnt <= cnt + CW'(1);
    end
  end

  // Result registers, captured on the final digit and held through HOLD and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_divisible <= 1'b0;
      out_remainder <= '0;
      out_binary    <= '0;
      out_bcd_err   <= 1'b0;
    end else if (last) begin
      out_divisible <= (rem_n == '0) && !err_n;
      out_remainder <= rem_n;
      out_binary    <= bin_n;
      out_bcd_err   <= err_n;
    end
  end

endmodule : bcd_divisibility_checker

// File: tb/tb_bcd_divisibility_checker.sv
// Directed bench for the BCD divisibility checker (DIVISOR=3 and DIVISOR=7 instances).
module tb_bcd_divisibility_checker;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_bcd;
  logic        out_ready;

  logic        iv3, ir3, ov3, div3, err3;
  logic [1:0]  rem3;
  logic [13:0] bin3;

  logic        iv7, ir7, ov7, div7, err7;
  logic [2:0]  rem7;
  logic [13:0] bin7;

  int ntests = 0;
  int nfail  = 0;
  int cur    = 3;

  logic        s_ir, s_ov, s_div, s_err;
  logic [31:0] s_rem, s_bin;

  bcd_divisibility_checker #(.NUM_DIGITS(4), .DIVISOR(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .in_bcd(in_bcd),
    .out_valid(ov3), .out_ready(out_ready), .out_divisible(div3),
    .out_remainder(rem3), .out_binary(bin3), .out_bcd_err(err3)
  );

  bcd_divisibility_checker #(.NUM_DIGITS(4), .DIVISOR(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv7), .in_ready(ir7), .in_bcd(in_bcd),
    .out_valid(ov7), .out_ready(out_ready), .out_divisible(div7),
    .out_remainder(rem7), .out_binary(bin7), .out_bcd_err(err7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (cur == 7) begin
      s_ir = ir7; s_ov = ov7; s_div = div7; s_err = err7;
      s_rem = 32'(rem7); s_bin = 32'(bin7);
    end else begin
      s_ir = ir3; s_ov = ov3; s_div = div3; s_err = err3;
      s_rem = 32'(rem3); s_bin = 32'(bin3);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (cur == 7) iv7 = v; else iv3 = v;
  endtask

  // Offer one word, check acceptance, latency and results; leaves result in HOLD.
  task automatic send(input logic [15:0] bcd);
    int lat;
    @(negedge clk);
    check("in_ready_before_accept", 32'(s_ir), 32'd1);
    in_bcd = bcd;
    set_valid(1'b1);
    @(negedge clk);
    set_valid(1'b0);
    check("in_ready_after_accept", 32'(s_ir), 32'd0);
    lat = 0;
    while (!s_ov && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
  endtask

  task automatic expect_result(input string tag, input logic [31:0] erem,
                               input logic [31:0] ebin, input logic ediv,
                               input logic eerr, input bit chk_bin);
    check({tag, "_rem"}, s_rem, erem);
    check({tag, "_div"}, 32'(s_div), 32'(ediv));
    check({tag, "_err"}, 32'(s_err), 32'(eerr));
    if (chk_bin) check({tag, "_bin"}, s_bin, ebin);
  endtask

  task automatic accept_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", 32'(s_ov), 32'd0);
    check("in_ready_after_handshake", 32'(s_ir), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_bcd    = 16'h0000;
    out_ready = 1'b0;
    iv3       = 1'b0;
    iv7       = 1'b0;
    cur       = 3;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(ov3), 32'd0);
    check("rst_div", 32'(div3), 32'd0);
    check("rst_rem", 32'(rem3), 32'd0);
    check("rst_bin", 32'(bin3), 32'd0);
    check("rst_err", 32'(err3), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_post_reset", 32'(ir3), 32'd1);

    // DIVISOR=3 basic words
    send(16'h9999);
    expect_result("w9999", 32'd0, 32'd9999, 1'b1, 1'b0, 1'b1);
    accept_result();
    check("idle_keeps_bin", s_bin, 32'd9999);

    send(16'h3796);
    expect_result("w3796", 32'd1, 32'd3796, 1'b0, 1'b0, 1'b1);
    accept_result();

    send(16'h0000);
    expect_result("w0000", 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    accept_result();

    // Malformed nibbles: raw-value remainder, err forces divisible low
    send(16'h1A23);
    expect_result("w1A23", 32'd1, 32'd2023, 1'b0, 1'b1, 1'b0);
    accept_result();

    send(16'h000C);
    expect_result("w000C", 32'd0, 32'd12, 1'b0, 1'b1, 1'b0);
    accept_result();

    // Error flag must not leak into the next word
    send(16'h0021);
    expect_result("w0021", 32'd0, 32'd21, 1'b1, 1'b0, 1'b1);
    accept_result();

    // DIVISOR=7 instance
    cur = 7;
    send(16'h0994);
    expect_result("d7_0994", 32'd0, 32'd994, 1'b1, 1'b0, 1'b1);
    accept_result();

    send(16'h1000);
    expect_result("d7_1000", 32'd6, 32'd1000, 1'b0, 1'b0, 1'b1);
    accept_result();

    // Back-pressure: hold result for 5 cycles while new words are offered
    cur = 3;
    send(16'h0012);
    for (int i = 0; i < 5; i++) begin
      in_bcd = 16'h5000 + 16'(i);
      iv3 = (i % 2 == 0);
      @(negedge clk);
      check("bp_in_ready", 32'(ir3), 32'd0);
      check("bp_out_valid", 32'(ov3), 32'd1);
      check("bp_rem", 32'(rem3), 32'd0);
      check("bp_bin", 32'(bin3), 32'd12);
      check("bp_div", 32'(div3), 32'd1);
    end
    iv3 = 1'b0;
    accept_result();
    check("bp_no_new_word_bin", 32'(bin3), 32'd12);

    // Reset two cycles into RUN aborts the operation
    @(negedge clk);
    in_bcd = 16'h5678;
    iv3 = 1'b1;
    @(negedge clk);
    iv3 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 32'(ov3), 32'd0);
    check("abort_rem", 32'(rem3), 32'd0);
    check("abort_bin", 32'(bin3), 32'd0);
    check("abort_div", 32'(div3), 32'd0);
    check("abort_err", 32'(err3), 32'd0);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (ov3) seen++;
      end
      check("abort_no_out_valid", 32'(seen), 32'd0);
    end

    send(16'h0024);
    expect_result("w0024", 32'd0, 32'd24, 1'b1, 1'b0, 1'b1);
    accept_result();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_bcd_divisibility_checker
